// File: rtl/eventsystem_timer.sv
// rtl/eventsystem_timer.sv - prescaled periodic/oneshot event timer with saturating pulse counter
module eventsystem_timer #(
    parameter int CNT_WIDTH = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_pulse,
    input  logic                 stop_pulse,
    input  logic                 oneshot,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic                 out_pulse,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pulse_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                 state, state_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [PRE_WIDTH-1:0]   prescale_q, prescale_d;
    logic                   oneshot_q, oneshot_d;
    logic [CNT_WIDTH-1:0]   tick_cnt, tick_cnt_d;
    logic [PRE_WIDTH-1:0]   pre_cnt, pre_cnt_d;
    logic                   out_pulse_d;
    logic [CNT_WIDTH-1:0]   pulse_count_d;
    logic [CNT_WIDTH-1:0]   period_eff;

    assign period_eff = (period == '0) ? CNT_ONE : period;
    assign busy       = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            period_q    <= '0;
            prescale_q  <= '0;
            oneshot_q   <= 1'b0;
            tick_cnt    <= '0;
            pre_cnt     <= '0;
            out_pulse   <= 1'b0;
            pulse_count <= '0;
        end else begin
            state       <= state_d;
            period_q    <= period_d;
            prescale_q  <= prescale_d;
            oneshot_q   <= oneshot_d;
            tick_cnt    <= tick_cnt_d;
            pre_cnt     <= pre_cnt_d;
            out_pulse   <= out_pulse_d;
            pulse_count <= pulse_count_d;
        end
    end

    always_comb begin
        state_d       = state;
        period_d      = period_q;
        prescale_d    = prescale_q;
        oneshot_d     = oneshot_q;
        tick_cnt_d    = tick_cnt;
        pre_cnt_d     = pre_cnt;
        out_pulse_d   = 1'b0;
        pulse_count_d = pulse_count;

        // stop wins over start, so a collision never re-latches or pulses
        if (stop_pulse) begin
            state_d = IDLE;
        end else if (start_pulse) begin
            period_d      = period_eff;
            prescale_d    = prescale;
            oneshot_d     = oneshot;
            tick_cnt_d    = period_eff;
            pre_cnt_d     = prescale;
            pulse_count_d = '0;
            state_d       = RUN;
        end else if (state == RUN) begin
            if (pre_cnt == '0) begin
                pre_cnt_d = prescale_q;
                if (tick_cnt == CNT_ONE) begin
                    out_pulse_d = 1'b1;
                    tick_cnt_d  = period_q;
                    if (pulse_count != CNT_MAX) begin
                        pulse_count_d = pulse_count + CNT_ONE;
                    end
                    if (oneshot_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt - CNT_ONE;
                end
            end else begin
                pre_cnt_d = pre_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eventsystem_timer.sv
// tb/tb_eventsystem_timer.sv - scoreboard testbench for eventsystem_timer
module tb_eventsystem_timer;

    localparam int CW = 4;
    localparam int PW = 8;

    typedef struct packed {
        logic          out;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start_pulse;
    logic          stop_pulse;
    logic          oneshot;
    logic [CW-1:0] period;
    logic [PW-1:0] prescale;
    logic          out_pulse;
    logic          busy;
    logic [CW-1:0] pulse_count;

    exp_t sb[$];
    int   checks;
    int   errors;

    eventsystem_timer #(.CNT_WIDTH(CW), .PRE_WIDTH(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .oneshot     (oneshot),
        .period      (period),
        .prescale    (prescale),
        .out_pulse   (out_pulse),
        .busy        (busy),
        .pulse_count (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic o, input logic b, input int c);
        exp_t e;
        e.out  = o;
        e.busy = b;
        e.cnt  = CW'(c);
        sb.push_back(e);
    endfunction

    task automatic tick(input string name, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s[%0d] scoreboard empty", name, idx);
        end else begin
            e = sb.pop_front();
            if (out_pulse !== e.out || busy !== e.busy || pulse_count !== e.cnt) begin
                errors++;
                $display("FAIL %s[%0d] got out=%b busy=%b cnt=%0d exp out=%b busy=%b cnt=%0d",
                         name, idx, out_pulse, busy, pulse_count, e.out, e.busy, e.cnt);
            end
        end
    endtask

    task automatic arm(input int p, input int s, input logic os);
        period      = CW'(p);
        prescale    = PW'(s);
        oneshot     = os;
        start_pulse = 1'b1;
    endtask

    task automatic check_now(input string name, input logic o, input logic b, input int c);
        checks++;
        if (out_pulse !== o || busy !== b || pulse_count !== CW'(c)) begin
            errors++;
            $display("FAIL %s got out=%b busy=%b cnt=%0d exp out=%b busy=%b cnt=%0d",
                     name, out_pulse, busy, pulse_count, o, b, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        check_now("reset_async", 1'b0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            push(0, 0, 0);
            tick("reset_hold", i);
        end
        rst = 1'b1;
        push(0, 0, 0);
        tick("reset_release", 0);
    endtask

    task automatic test_periodic();
        arm(4, 0, 1'b0);
        push(0, 1, 0);
        tick("per", 0);
        period   = CW'(1);
        prescale = PW'(5);
        oneshot  = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            push(e % 4 == 0, 1, e / 4);
            tick("per", e);
        end
        stop_pulse = 1'b1;
        push(0, 0, 3);
        tick("per_stop", 13);
    endtask

    task automatic test_oneshot();
        arm(3, 2, 1'b1);
        push(0, 1, 0);
        tick("osh", 0);
        for (int e = 1; e <= 14; e++) begin
            push(e == 9, e < 9, (e >= 9) ? 1 : 0);
            tick("osh", e);
        end
    endtask

    task automatic test_stop_collision();
        arm(4, 0, 1'b0);
        push(0, 1, 0);
        tick("stop", 0);
        for (int e = 1; e <= 7; e++) begin
            push(e == 4, 1, (e >= 4) ? 1 : 0);
            tick("stop", e);
        end
        stop_pulse = 1'b1;
        push(0, 0, 1);
        tick("stop", 8);
        for (int e = 9; e <= 11; e++) begin
            push(0, 0, 1);
            tick("stop_idle", e);
        end
        arm(2, 0, 1'b0);
        stop_pulse = 1'b1;
        push(0, 0, 1);
        tick("collide", 0);
        for (int e = 1; e <= 4; e++) begin
            push(0, 0, 1);
            tick("collide_idle", e);
        end
    endtask

    task automatic test_restart();
        arm(4, 0, 1'b0);
        push(0, 1, 0);
        tick("restart", 0);
        for (int e = 1; e <= 2; e++) begin
            push(0, 1, 0);
            tick("restart", e);
        end
        arm(2, 0, 1'b0);
        push(0, 1, 0);
        tick("restart", 3);
        for (int e = 4; e <= 9; e++) begin
            push((e - 3) % 2 == 0, 1, (e - 3) / 2);
            tick("restart", e);
        end
        stop_pulse = 1'b1;
        push(0, 0, 3);
        tick("restart_stop", 10);
    endtask

    task automatic test_saturate();
        arm(0, 0, 1'b0);
        push(0, 1, 0);
        tick("sat", 0);
        for (int e = 1; e <= 20; e++) begin
            push(1, 1, (e > 15) ? 15 : e);
            tick("sat", e);
        end
        stop_pulse = 1'b1;
        push(0, 0, 15);
        tick("sat_stop", 21);
    endtask

    task automatic test_async_reset();
        arm(4, 0, 1'b0);
        push(0, 1, 0);
        tick("areset", 0);
        for (int e = 1; e <= 4; e++) begin
            push(e == 4, 1, (e == 4) ? 1 : 0);
            tick("areset", e);
        end
        #2;
        rst = 1'b0;
        #1;
        check_now("areset_mid", 1'b0, 1'b0, 0);
        rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            push(0, 0, 0);
            tick("areset_after", e);
        end
        arm(1, 0, 1'b0);
        push(0, 1, 0);
        tick("areset_rearm", 0);
        for (int e = 1; e <= 2; e++) begin
            push(1, 1, e);
            tick("areset_rearm", e);
        end
        stop_pulse = 1'b1;
        push(0, 0, 2);
        tick("areset_stop", 3);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        oneshot     = 1'b0;
        period      = '0;
        prescale    = '0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_stop_collision();
        test_restart();
        test_saturate();
        test_async_reset();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
